// File: rtl/dmem_vga_arbiter_if.sv
// Bus bundle between the data-memory arbiter and its three neighbours:
// the core load/store port, the VGA pixel-word consumer and the single-port dmem.
interface dmem_vga_arbiter_if #(
   parameter int ADDR_W = 9
);
   logic              cpu_req;
   logic              cpu_we;
   logic [31:0]       cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [31:0]       cpu_rdata;

   logic              vga_frame_start;
   logic              vga_pop;
   logic              vga_valid;
   logic [31:0]       vga_data;
   logic              vga_underflow;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata,
      input  vga_frame_start, vga_pop,
      output vga_valid, vga_data, vga_underflow,
      output ram_addr, ram_we, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata,
      output vga_frame_start, vga_pop,
      input  vga_valid, vga_data, vga_underflow,
      input  ram_addr, ram_we, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/dmem_vga_arbiter.sv
// Shares one single-port dmem between the core (always wins) and a framebuffer
// prefetcher that fills a small FIFO in cycles the core leaves the memory idle.
module dmem_vga_arbiter #(
   parameter int ADDR_W     = 9,
   parameter int FB_BASE    = 0,
   parameter int FB_WORDS   = 75,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   dmem_vga_arbiter_if.slave      bus
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = ADDR_W + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [RW-1:0] fetchPtr_q, fetchPtr_d;
   logic [RW-1:0] remaining_q, remaining_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic          underflow_q, underflow_d;
   logic [31:0]   fifoMem_q [FIFO_DEPTH];

   logic          pushEn;
   logic          popEn;
   logic          unusedBits;

   // Fetch pointer is one bit wider than the RAM address so it can sit one past
   // the last word of a framebuffer ending at the top of memory without wrapping.
   assign unusedBits = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0], fetchPtr_q[ADDR_W]};

   assign bus.ram_addr  = bus.cpu_req ? bus.cpu_addr[ADDR_W+1:2] : fetchPtr_q[ADDR_W-1:0];
   assign bus.ram_we    = bus.cpu_req & bus.cpu_we & ~reset;
   assign bus.ram_wdata = bus.cpu_wdata;
   assign bus.cpu_rdata = bus.ram_rdata;

   assign bus.vga_valid     = (count_q != '0);
   assign bus.vga_data      = (count_q != '0) ? fifoMem_q[rdPtr_q] : 32'h0;
   assign bus.vga_underflow = underflow_q;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
   assign pushEn = (state_q == FETCH) && !bus.cpu_req &&
                   ((count_q < CW'(FIFO_DEPTH)) || bus.vga_pop);
   assign popEn  = bus.vga_pop && (count_q != '0);

   always_comb begin
      state_d     = state_q;
      fetchPtr_d  = fetchPtr_q;
      remaining_d = remaining_q;
      count_d     = count_q;
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      underflow_d = underflow_q;

      if (bus.vga_frame_start) begin
         state_d     = FETCH;
         fetchPtr_d  = RW'(FB_BASE);
         remaining_d = RW'(FB_WORDS);
         count_d     = '0;
         wrPtr_d     = '0;
         rdPtr_d     = '0;
         underflow_d = 1'b0;
      end else begin
         if (pushEn) begin
            fetchPtr_d  = fetchPtr_q + RW'(1);
            remaining_d = remaining_q - RW'(1);
            wrPtr_d     = wrPtr_q + PW'(1);
            if (remaining_q == RW'(1)) begin
               state_d = DONE;
            end
         end
         if (popEn) begin
            rdPtr_d = rdPtr_q + PW'(1);
         end
         if (bus.vga_pop && (count_q == '0)) begin
            underflow_d = 1'b1;
         end
         count_d = count_q + CW'(pushEn) - CW'(popEn);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         fetchPtr_q  <= RW'(FB_BASE);
         remaining_q <= '0;
         count_q     <= '0;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetchPtr_q  <= fetchPtr_d;
         remaining_q <= remaining_d;
         count_q     <= count_d;
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage needs no reset: the count alone decides what is visible.
   always_ff @(posedge clk) begin
      if (pushEn && !bus.vga_frame_start) begin
         fifoMem_q[wrPtr_q] <= bus.ram_rdata;
      end
   end

endmodule
